// File: rtl/i2c_write_burst.sv
// Claims the shared I2C master and issues one write: device address, a 1..2 byte
// register address (MSB first), then up to MAX_BYTES payload bytes from a valid/ready source.
module i2c_write_burst #(
    parameter int REG_ADDR_BYTES = 1,
    parameter int MAX_BYTES      = 16,
    parameter int CNT_W          = 5,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [6:0]                  dev_address,
    input  logic [8*REG_ADDR_BYTES-1:0] reg_address,
    input  logic [CNT_W-1:0]            byte_count,
    input  logic [7:0]                  data_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    input  logic                        i2c_cmd_ready,
    input  logic                        i2c_data_out_ready,
    input  logic                        i2c_bus_busy,
    input  logic                        i2c_bus_control,
    input  logic                        i2c_bus_active,
    input  logic                        i2c_missed_ack,
    output logic [6:0]                  i2c_dev_address,
    output logic                        i2c_cmd_start,
    output logic                        i2c_cmd_write_multiple,
    output logic                        i2c_cmd_stop,
    output logic                        i2c_cmd_valid,
    output logic [7:0]                  i2c_data_out,
    output logic                        i2c_data_out_valid,
    output logic                        i2c_data_out_last,
    input  logic                        i2c_relinquish,
    output logic                        i2c_control,
    output logic                        busy,
    output logic                        done,
    output logic                        message_failure,
    output logic [3:0]                  state_out
);
    // valid/ready: a byte or command moves on a clock edge where valid & ready are both
    // high; once valid rises it holds, with stable data, until that edge. Ready never
    // feeds valid combinationally.

    localparam int RA_W  = 8 * REG_ADDR_BYTES;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BYTES);
    localparam logic [1:0]       LAST_IDX = 2'(REG_ADDR_BYTES - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WAIT_BUS  = 4'd1;
    localparam logic [3:0] S_CMD       = 4'd2;
    localparam logic [3:0] S_ADDR      = 4'd3;
    localparam logic [3:0] S_DATA      = 4'd4;
    localparam logic [3:0] S_WAIT_FREE = 4'd5;
    localparam logic [3:0] S_DONE      = 4'd6;
    localparam logic [3:0] S_FAIL      = 4'd7;

    logic [3:0]       state_q, state_d;
    logic [6:0]       dev_q, dev_d;
    logic [RA_W-1:0]  reg_q, reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             last_q, last_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic waiting, fault, out_xfer, reload;

    function automatic logic [7:0] addr_byte_at(input logic [RA_W-1:0] ra, input logic [1:0] idx);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < REG_ADDR_BYTES; i++) begin
            if (idx == 2'(i)) b = ra[8*(REG_ADDR_BYTES-1-i) +: 8];
        end
        return b;
    endfunction

    always_comb begin
        waiting = (state_q == S_WAIT_BUS) || (state_q == S_CMD) || (state_q == S_ADDR) ||
                  (state_q == S_DATA) || (state_q == S_WAIT_FREE);
        fault    = waiting && (i2c_missed_ack || (tmr_q == '0));
        out_xfer = out_valid_q && i2c_data_out_ready;
        // The source byte is only taken when the transaction is not being torn down.
        data_in_ready = (state_q == S_DATA) && !out_valid_q && data_in_valid &&
                        (sent_q < cnt_q) && !i2c_relinquish && !fault;
    end

    always_comb begin
        state_d     = state_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        cnt_d       = cnt_q;
        sent_d      = sent_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        reload      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !i2c_relinquish) begin
                    state_d = S_WAIT_BUS;
                    dev_d   = dev_address;
                    reg_d   = reg_address;
                    cnt_d   = (byte_count > MAX_CNT) ? MAX_CNT : byte_count;
                    sent_d  = '0;
                    idx_d   = '0;
                end
            end
            S_WAIT_BUS: begin
                if (!i2c_bus_busy && !i2c_bus_active) state_d = S_CMD;
            end
            S_CMD: begin
                if (i2c_cmd_ready) begin
                    state_d     = S_ADDR;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_d       = addr_byte_at(reg_q, 2'd0);
                    last_d      = (LAST_IDX == 2'd0) && (cnt_q == '0);
                end
            end
            S_ADDR: begin
                if (out_xfer) begin
                    reload = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        state_d     = (cnt_q == '0) ? S_WAIT_FREE : S_DATA;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        out_d  = addr_byte_at(reg_q, idx_q + 2'd1);
                        last_d = ((idx_q + 2'd1) == LAST_IDX) && (cnt_q == '0);
                    end
                end
            end
            S_DATA: begin
                if (out_xfer) begin
                    reload      = 1'b1;
                    out_valid_d = 1'b0;
                    sent_d      = sent_q + CNT_W'(1);
                    if ((sent_q + CNT_W'(1)) == cnt_q) state_d = S_WAIT_FREE;
                end else if (data_in_ready) begin
                    out_valid_d = 1'b1;
                    out_d       = data_in;
                    last_d      = (sent_q + CNT_W'(1)) == cnt_q;
                end
            end
            S_WAIT_FREE: begin
                if (!i2c_bus_busy && !i2c_bus_control) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Relinquish outranks a missed ack or timeout: leave silently.
        if (fault) state_d = S_FAIL;
        if (i2c_relinquish) state_d = S_IDLE;

        if ((state_d != S_ADDR) && (state_d != S_DATA)) out_valid_d = 1'b0;
        if (!out_valid_d) begin
            out_d  = '0;
            last_d = 1'b0;
        end

        if ((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_FAIL)) begin
            tmr_d = '0;
        end else if ((state_d != state_q) || reload) begin
            tmr_d = TMR_LOAD;
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
        end else begin
            tmr_d = tmr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dev_q       <= '0;
            reg_q       <= '0;
            cnt_q       <= '0;
            sent_q      <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            cnt_q       <= cnt_d;
            sent_q      <= sent_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            tmr_q       <= tmr_d;
        end
    end

    assign i2c_cmd_valid          = (state_q == S_CMD);
    assign i2c_cmd_start          = (state_q == S_CMD);
    assign i2c_cmd_write_multiple = (state_q == S_CMD);
    assign i2c_cmd_stop           = (state_q == S_CMD);
    assign i2c_dev_address        = (state_q == S_CMD) ? dev_q : 7'd0;
    assign i2c_data_out           = out_q;
    assign i2c_data_out_valid     = out_valid_q;
    assign i2c_data_out_last      = last_q;
    assign i2c_control            = waiting;
    assign busy                   = (state_q != S_IDLE);
    assign done                   = (state_q == S_DONE) || (state_q == S_FAIL);
    assign message_failure        = (state_q == S_FAIL);
    assign state_out              = state_q;

endmodule

// File: doc/i2c_write_burst.md
Name: i2c_write_burst

Overview:
- Parametrised successor to the single-byte I2C register writer in SensorModule.
- Claims the shared I2C master and issues one write transaction: device address, a 1..REG_ADDR_BYTES-byte register address (MSB first), then 0..MAX_BYTES payload bytes streamed from a valid/ready source.
- Used for sensor bulk configuration: multi-byte registers and auto-increment block writes.
- Replaces the external timer handshake with an internal per-phase timeout counter.

Parameters:
- REG_ADDR_BYTES, 1, register address width in bytes (1 or 2).
- MAX_BYTES, 16, maximum payload bytes per transaction.
- CNT_W, 5, width of byte_count (must satisfy 2^CNT_W > MAX_BYTES).
- TIMEOUT_CYCLES, 100000, clk cycles allowed in any single wait phase.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin transaction; sampled in IDLE only
- dev_address  in  7  target device address
- reg_address  in  8*REG_ADDR_BYTES  target register address
- byte_count  in  CNT_W  payload length
- data_in  in  8  payload byte
- data_in_valid  in  1  payload byte available
- data_in_ready  out  1  payload byte accepted this cycle
- i2c_cmd_ready  in  1  master accepts command
- i2c_data_out_ready  in  1  master accepts byte
- i2c_bus_busy  in  1  master status
- i2c_bus_control  in  1  master status
- i2c_bus_active  in  1  master status
- i2c_missed_ack  in  1  master status
- i2c_dev_address  out  7  command address
- i2c_cmd_start  out  1  command start flag
- i2c_cmd_write_multiple  out  1  command write-multiple flag
- i2c_cmd_stop  out  1  command stop flag
- i2c_cmd_valid  out  1  command valid
- i2c_data_out  out  8  byte to master
- i2c_data_out_valid  out  1  byte valid
- i2c_data_out_last  out  1  final byte of transaction
- i2c_relinquish  in  1  another I2C module takes the bus; abort immediately
- i2c_control  out  1  high while this block owns the master
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse on transaction end (success or failure)
- message_failure  out  1  one-cycle pulse with done on failure
- state_out  out  4  current state, for debug

Behaviour:
- Reset: state IDLE. All outputs 0, counters 0.
- Latching: at start in IDLE, latch dev_address, reg_address and byte_count.
  - Latched count = min(byte_count, MAX_BYTES).
  - Total bytes N = REG_ADDR_BYTES + count.
- States:
  - IDLE: start -> WAIT_BUS. Set i2c_control=1. Load timeout.
  - WAIT_BUS: ~i2c_bus_busy & ~i2c_bus_active -> CMD.
  - CMD: drive i2c_cmd_start=1, i2c_cmd_write_multiple=1, i2c_cmd_stop=1, i2c_cmd_valid=1. On cmd_valid & cmd_ready -> ADDR; cmd_valid drops the next cycle.
  - ADDR: present address bytes MSB first with i2c_data_out_valid=1. Each byte transfers on valid & ready; next byte is presented the cycle after. After the final address byte: count==0 -> WAIT_FREE, else -> DATA.
  - DATA: output register empty & data_in_valid -> data_in_ready=1 for one cycle and the byte loads into i2c_data_out with valid=1. Byte transfers on valid & ready. After count transfers -> WAIT_FREE.
  - WAIT_FREE: ~i2c_bus_busy & ~i2c_bus_control -> DONE.
  - DONE: done=1 for one cycle, i2c_control=0 -> IDLE.
- i2c_data_out_last = 1 exactly while byte N is valid.
- Handshakes: valid, once raised, holds and its data stays stable until ready. No combinational ready-to-valid path.
- Timeout: counter reloads to TIMEOUT_CYCLES on entering each state, and on every accepted byte in ADDR/DATA. Reaching 0 in a waiting state -> FAIL.
  - Fatal waits: bus never free, cmd_ready or data_out_ready never asserted, data_in_valid stalled.
- FAIL: done=1 and message_failure=1 for one cycle. Drop all valids and i2c_control -> IDLE.
- i2c_missed_ack in any state other than IDLE/DONE -> FAIL next cycle.
- i2c_relinquish, or relinquish coinciding with start: -> IDLE next cycle, all outputs 0, no done, no failure. Relinquish has priority over missed_ack and timeout.
- start while busy: ignored. Input changes after latching do not affect the transaction in progress.
- Async reset mid-transaction: immediate IDLE, all outputs 0.

Test Plan:
- Basic: REG_ADDR_BYTES=1, dev 0x21, reg 0x3A, count 3, data 0x11,0x22,0x33, always-ready master.
  -> one command (start/wm/stop=1); bytes 0x3A,0x11,0x22,0x33; last only on 0x33; done pulse; no failure.
- 16-bit address, count 0: REG_ADDR_BYTES=2, reg 0x1234.
  -> bytes 0x12 then 0x34 with last on 0x34; data_in_ready never asserted; done pulse.
- Clamp and backpressure: count 20, MAX_BYTES=16; master ready toggling 1-of-3 cycles and the source inserting gaps.
  -> exactly 1+16 bytes; data held stable while not ready; 16 data_in_ready pulses.
- Timeouts: TIMEOUT_CYCLES=50 with i2c_bus_busy stuck high.
  -> done and message_failure pulse 51 cycles after start; i2c_control=0.
  -> Same result when data_in_valid is stalled in DATA.
- Missed ack: assert i2c_missed_ack during the second byte.
  -> FAIL pulse next cycle; all valids low; a new start then completes normally.
- Abort and reset: i2c_relinquish during DATA -> IDLE, no done/failure. Async reset mid-CMD -> all outputs 0 without waiting for a clk edge.
